// File: rtl/raster_reader.sv
// Drains an 8-bit pixel FIFO into a framed valid/ready raster stream with x/y and line/frame marks.
// Optional RASTER_READER_STALL_CNT_EN adds underrun_cnt, counting starved RUN cycles.
module raster_reader #(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64,
    parameter int unsigned XW    = $clog2(IMG_W),
    parameter int unsigned YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          fifo_empty,
    input  logic [7:0]    fifo_data_out,
    output logic          fifo_rd,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [7:0]    pix_data,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          pix_sol,
    output logic          pix_eol,
    output logic          pix_sof,
    output logic          pix_eof,
    output logic          busy,
    output logic          done
`ifdef RASTER_READER_STALL_CNT_EN
    ,
    output logic [15:0]   underrun_cnt
`endif
);

    localparam int unsigned   TOTAL   = IMG_W * IMG_H;
    localparam int unsigned   CW      = $clog2(TOTAL + 1);
    localparam logic [CW-1:0] RD_LAST = CW'(TOTAL);
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic          inflight_q;
    logic [1:0]    occ_q;
    logic [7:0]    buf0_q, buf1_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          pop, tail_hi, frame_start;
    logic [1:0]    fill_after;

    assign pix_data    = buf0_q;
    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign pix_sol     = (x_q == '0);
    assign pix_eol     = (x_q == X_LAST);
    assign pix_sof     = (x_q == '0) && (y_q == '0);
    assign pix_eof     = (x_q == X_LAST) && (y_q == Y_LAST);
    assign busy        = (state_q == StRun) || (state_q == StDrain);
    assign done        = (state_q == StDone);
    assign frame_start = (state_q == StIdle) && start;

    always_comb begin
        state_d    = state_q;
        pix_valid  = (occ_q != 2'd0);
        pop        = pix_valid && pix_ready;
        // Fill counted after this cycle's pop so a full pipeline still issues every cycle.
        fill_after = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        tail_hi    = ((occ_q - {1'b0, pop}) != 2'd0);
        fifo_rd    = (state_q == StRun) && !fifo_empty && (fill_after < 2'd2) &&
                     (rd_cnt_q != RD_LAST);
        rd_cnt_d   = rd_cnt_q + {{(CW-1){1'b0}}, fifo_rd};
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (rd_cnt_d == RD_LAST) state_d = StDrain;
            StDrain: if (pop && pix_eof) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rd_cnt_q   <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            buf0_q     <= 8'h00;
            buf1_q     <= 8'h00;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_rd;
            occ_q      <= fill_after;
            if (pop) buf0_q <= buf1_q;
            if (inflight_q) begin
                if (tail_hi) buf1_q <= fifo_data_out;
                else         buf0_q <= fifo_data_out;
            end
            if (frame_start) begin
                rd_cnt_q <= '0;
                x_q      <= '0;
                y_q      <= '0;
            end else begin
                rd_cnt_q <= rd_cnt_d;
                if (pop) begin
                    if (x_q == X_LAST) begin
                        x_q <= '0;
                        y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                    end else begin
                        x_q <= x_q + 1'b1;
                    end
                end
            end
        end
    end

`ifdef RASTER_READER_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            underrun_cnt <= 16'h0000;
        end else if ((state_q == StRun) && fifo_empty && (occ_q == 2'd0) &&
                     (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_raster_reader.sv
// Randomised bench for raster_reader (4x2 frames) against a queue-based frame model.
module tb_raster_reader;

    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst, start, fifo_empty, fifo_rd, pix_valid, pix_ready;
    logic [7:0] fifo_data_out = 8'h00;
    logic [7:0] pix_data;
    logic [1:0] pix_x;
    logic [0:0] pix_y;
    logic       pix_sol, pix_eol, pix_sof, pix_eof, busy, done;

    raster_reader #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .start(start), .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out), .fifo_rd(fifo_rd), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_sof(pix_sof), .pix_eof(pix_eof),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // FIFO model: bench writes mem/wr_ptr, DUT reads advance rd_ptr.
    logic [7:0] mem [0:4095];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       flush = 1'b0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (flush) rd_ptr <= wr_ptr;
        else if (fifo_rd && !fifo_empty) begin
            fifo_data_out <= mem[rd_ptr[11:0]];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    int   n_tests = 0, n_fail = 0;
    logic [7:0] exp_q[$];
    int   phase = 0;  // 0 idle, 1 frame active, 2 done cycle
    int   ready_mode = 0, cyc = 0, tf_idx = 0, rd_issued = 0, sof_count = 0, frames_done = 0;
    int   start_cyc = 0, first_rd_cyc = -1, first_tf_cyc = -1, last_tf_cyc = -1;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic [1:0] prev_x;
    logic [0:0] prev_y;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[11:0]] = b;
        wr_ptr++;
        exp_q.push_back(b);
    endtask

    task automatic tick();
        logic       xfer, last;
        logic [7:0] eb;
        @(negedge clk);
        cyc++;
        check("done", {31'd0, done}, {31'd0, phase == 2});
        check("busy", {31'd0, busy}, {31'd0, phase == 1});
        if (phase != 1) check("idle_valid", {31'd0, pix_valid}, 0);
        if (phase == 0) check("idle_rd", {31'd0, fifo_rd}, 0);
        if (prev_stall) begin
            check("hold_valid", {31'd0, pix_valid}, 1);
            check("hold_data", {24'd0, pix_data}, {24'd0, prev_data});
            check("hold_x", {30'd0, pix_x}, {30'd0, prev_x});
            check("hold_y", {31'd0, pix_y}, {31'd0, prev_y});
        end
        if (fifo_rd) begin
            check("rd_when_empty", {31'd0, fifo_empty}, 0);
            rd_issued++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
        end
        xfer = pix_valid && pix_ready;
        last = 1'b0;
        if (xfer) begin
            if (exp_q.size() == 0) check("extra_pix", {31'd0, pix_valid}, 0);
            else begin
                eb = exp_q.pop_front();
                check("data", {24'd0, pix_data}, {24'd0, eb});
                check("x", {30'd0, pix_x}, tf_idx % W);
                check("y", {31'd0, pix_y}, tf_idx / W);
                check("sol", {31'd0, pix_sol}, {31'd0, (tf_idx % W) == 0});
                check("eol", {31'd0, pix_eol}, {31'd0, (tf_idx % W) == W - 1});
                check("sof", {31'd0, pix_sof}, {31'd0, tf_idx == 0});
                check("eof", {31'd0, pix_eof}, {31'd0, tf_idx == N - 1});
            end
            if (pix_sof) sof_count++;
            if (tf_idx == 0) first_tf_cyc = cyc;
            if (tf_idx == N - 1) begin
                last_tf_cyc = cyc;
                last = 1'b1;
            end
            tf_idx++;
        end
        if (phase == 1) begin
            check("outstanding", {31'd0, (rd_issued - tf_idx) <= 2}, 1);
            check("rd_total", {31'd0, rd_issued <= N}, 1);
        end
        prev_stall = pix_valid && !pix_ready;
        prev_data  = pix_data;
        prev_x     = pix_x;
        prev_y     = pix_y;
        case (phase)
            0: if (start) begin
                phase = 1; tf_idx = 0; rd_issued = 0; start_cyc = cyc;
                first_rd_cyc = -1; first_tf_cyc = -1; last_tf_cyc = -1;
            end
            1: if (last) phase = 2;
            default: begin phase = 0; frames_done++; end
        endcase
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = ~pix_ready;
            default: pix_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic run_frame(input int bound);
        int n = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (phase != 0 && n < bound) begin
            tick();
            n++;
        end
        check("frame_timeout", phase, 0);
        check("leftover", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush = 1'b0;
        phase = 0; prev_stall = 1'b0; tf_idx = 0; rd_issued = 0;
        @(negedge clk);
        check("rst_valid", {31'd0, pix_valid}, 0);
        check("rst_x", {30'd0, pix_x}, 0);
        check("rst_y", {31'd0, pix_y}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_rd", {31'd0, fifo_rd}, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int pushed;
        rst = 1'b1; start = 1'b0; pix_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_data", {24'd0, pix_data}, 0);
        check("rst_done", {31'd0, done}, 0);

        // Idle with data waiting: nothing may be read without start.
        for (int i = 0; i < N; i++) push(8'(8'h10 + i));
        repeat (5) tick();

        // Full-rate frame.
        run_frame(40);
        check("lat_rd", first_rd_cyc - start_cyc, 1);
        check("lat_pix", first_tf_cyc - start_cyc, 3);
        check("burst", last_tf_cyc - first_tf_cyc, N - 1);

        // Ready toggling.
        ready_mode = 1;
        for (int i = 0; i < N; i++) push(8'(8'h10 + i));
        run_frame(60);

        // FIFO runs dry after three bytes, refills ten cycles later.
        ready_mode = 0;
        for (int i = 0; i < 3; i++) push(8'(8'h20 + i));
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        for (int i = 3; i < N; i++) push(8'(8'h20 + i));
        n = 0;
        while (phase != 0 && n < 40) begin tick(); n++; end
        check("gap_timeout", phase, 0);
        check("gap_leftover", exp_q.size(), 0);

        // Reset after the fifth transfer, then a clean restart.
        for (int i = 0; i < N; i++) push(8'(8'h30 + i));
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (tf_idx < 5 && n < 40) begin tick(); n++; end
        check("pre_reset_count", tf_idx, 5);
        do_reset();
        for (int i = 0; i < N; i++) push(8'(8'h40 + i));
        run_frame(40);

        // Start held across two frames.
        sof_count = 0;
        frames_done = 0;
        for (int i = 0; i < 2 * N; i++) push(8'(8'h50 + i));
        start = 1'b1;
        n = 0;
        while (frames_done < 2 && n < 100) begin tick(); n++; end
        start = 1'b0;
        repeat (4) tick();
        check("sof_twice", sof_count, 2);
        check("held_leftover", exp_q.size(), 0);

        // Random ready and random FIFO arrival.
        ready_mode = 2;
        for (int f = 0; f < 6; f++) begin
            pushed = 0;
            start = 1'b1;
            tick();
            start = 1'b0;
            n = 0;
            while (phase != 0 && n < 500) begin
                if (pushed < N && $urandom_range(0, 2) != 0) begin
                    push(8'($urandom));
                    pushed++;
                end
                tick();
                n++;
            end
            check("rand_timeout", phase, 0);
            check("rand_leftover", exp_q.size(), 0);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
